bin16_to_bcd_seq: RTL and testbench

Sequential 16-bit binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly downstream of the 16-bit counter. It takes the counter's binary value and produces five BCD digits, so the 7-segment decoders show the count in decimal (0–65535) instead of hex. A start/busy/done handshake lets the producer request a conversion whenever the count changes.

---
 rtl/bin16_to_bcd_seq.sv | 95 +++++++++
 tb/tb_bin16_to_bcd_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bin16_to_bcd_seq.sv
// 16-bit binary to 5-digit BCD, double dabble one bit per clock; Done 16 cycles after accepted Start.
// No backpressure: Start is only sampled in IDLE, ignored (not queued) while Busy or Done.
module bin16_to_bcd_seq (
    input  logic        CLOCK_50,
    input  logic        Resetn,
    input  logic        Start,
    input  logic [15:0] Bin,
    output logic        Busy,
    output logic        Done,
    output logic [19:0] BCD
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_s;
    logic [19:0] r_z;
    logic [3:0]  r_n;
    logic [19:0] r_bcd;

    logic [15:0] w_z_adj_lo;
    logic [2:0]  w_top_adj;
    logic [19:0] w_z_shift;

    // Per-digit add-3 with no carry between digits.
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_adj
            assign w_z_adj_lo[4*g +: 4] = (r_z[4*g +: 4] >= 4'd5) ? (r_z[4*g +: 4] + 4'd3)
                                                                  : r_z[4*g +: 4];
        end
    endgenerate

    // The top digit's MSB is shifted out, so only its low three adjusted bits matter.
    assign w_top_adj = (r_z[19:16] >= 4'd5) ? (r_z[18:16] + 3'd3) : r_z[18:16];
    assign w_z_shift = {w_top_adj, w_z_adj_lo, r_s[15]};

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (Start) w_next_state = ST_SHIFT;
            ST_SHIFT: if (r_n == 4'd15) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (r_state)
            ST_SHIFT: Busy = 1'b1;
            ST_DONE:  Done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_s   <= 16'd0;
            r_z   <= 20'd0;
            r_n   <= 4'd0;
            r_bcd <= 20'd0;
        end else begin
            if (r_state == ST_IDLE && Start) begin
                r_s <= Bin;
                r_z <= 20'd0;
                r_n <= 4'd0;
            end else if (r_state == ST_SHIFT) begin
                r_s <= {r_s[14:0], 1'b0};
                r_z <= w_z_shift;
                r_n <= r_n + 4'd1;
                if (r_n == 4'd15) begin
                    r_bcd <= w_z_shift;
                end
            end
        end
    end

    assign BCD = r_bcd;

endmodule

// File: tb/tb_bin16_to_bcd_seq.sv
// Scoreboard bench for bin16_to_bcd_seq: stimulus pushes decimal-digit expectations, monitor pops on Done.
module tb_bin16_to_bcd_seq;

    logic        CLOCK_50 = 1'b0;
    logic        Resetn   = 1'b0;
    logic        Start    = 1'b0;
    logic [15:0] Bin      = 16'd0;
    logic        Busy;
    logic        Done;
    logic [19:0] BCD;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [19:0] exp_q[$];

    bin16_to_bcd_seq dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .Start    (Start),
        .Bin      (Bin),
        .Busy     (Busy),
        .Done     (Done),
        .BCD      (BCD)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc++;

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int rem;
        r   = '0;
        rem = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pop on Done, exclusivity, busy run length, BCD stability.
    int          busy_run = 0;
    logic [19:0] prev_bcd = '0;
    always @(negedge CLOCK_50) begin
        if (Resetn) begin
            chk("busy_done_exclusive", {31'd0, Busy & Done}, 32'd0);
            if (Done) begin
                chk("busy_len", busy_run, 16);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got Done with BCD 0x%0h, expected no Done", BCD);
                end else begin
                    chk("bcd_result", {12'd0, BCD}, {12'd0, exp_q.pop_front()});
                end
            end else if (BCD !== prev_bcd) begin
                checks++;
                errors++;
                $display("FAIL bcd_hold: got 0x%0h expected 0x%0h", BCD, prev_bcd);
            end
            busy_run = Busy ? busy_run + 1 : 0;
        end else begin
            busy_run = 0;
        end
        prev_bcd = BCD;
    end

    task automatic wait_done();
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            if (Done) break;
        end
        if (i == 40) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no Done in 40 cycles, expected Done");
        end
    endtask

    task automatic convert(input logic [15:0] v);
        @(negedge CLOCK_50);
        Start = 1'b1;
        Bin   = v;
        exp_q.push_back(ref_bcd(int'(v)));
        @(negedge CLOCK_50);
        Start = 1'b0;
        Bin   = 16'($urandom);
        wait_done();
        @(negedge CLOCK_50);
    endtask

    logic [15:0] corner[14] = '{16'd0, 16'd65535, 16'd9999, 16'd10000, 16'd1234, 16'd1,
                                16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000,
                                16'd59999, 16'd60000};

    initial begin
        int t_prev;
        // Reset state
        #12;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_bcd", {12'd0, BCD}, 32'd0);
        @(negedge CLOCK_50);
        Resetn = 1'b1;

        foreach (corner[k]) convert(corner[k]);

        // Start during SHIFT is ignored; Bin changes after capture are ignored.
        @(negedge CLOCK_50);
        Start = 1'b1;
        Bin   = 16'd500;
        exp_q.push_back(ref_bcd(500));
        @(negedge CLOCK_50);
        Start = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        Start = 1'b1;
        Bin   = 16'd42;
        @(negedge CLOCK_50);
        Start = 1'b0;
        Bin   = 16'($urandom);
        wait_done();
        repeat (4) @(negedge CLOCK_50);
        chk("ignored_start_idle", {31'd0, Busy}, 32'd0);

        // Start held high: one conversion per 18 cycles.
        Start = 1'b1;
        Bin   = 16'd7;
        repeat (3) exp_q.push_back(ref_bcd(7));
        wait_done();
        t_prev = cyc;
        for (int k = 0; k < 2; k++) begin
            wait_done();
            chk("held_period", cyc - t_prev, 18);
            t_prev = cyc;
        end
        Start = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        // Reset mid-conversion discards the result.
        convert(16'd321);
        @(negedge CLOCK_50);
        Start = 1'b1;
        Bin   = 16'd999;
        @(negedge CLOCK_50);
        Start = 1'b0;
        repeat (7) @(posedge CLOCK_50);
        #2;
        Resetn = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, Busy}, 32'd0);
        chk("midrst_done", {31'd0, Done}, 32'd0);
        chk("midrst_bcd", {12'd0, BCD}, 32'd0);
        repeat (2) @(negedge CLOCK_50);
        Resetn = 1'b1;
        repeat (25) @(negedge CLOCK_50);
        chk("midrst_idle", {31'd0, Busy}, 32'd0);
        convert(16'd999);

        // Randomised sweep against the decimal reference.
        for (int k = 0; k < 1000; k++) convert(16'($urandom));

        repeat (5) @(negedge CLOCK_50);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
